// File: rtl/stateless_seq.sv
// rtl/stateless_seq.sv - micro-sequencer stepping one stateless ALU atom through a per-packet program
module stateless_seq #(
  parameter int DEPTH       = 8,
  parameter int COUNT_WIDTH = 32,
  parameter int AW          = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [15:0]            cfg_instr,
  input  logic [COUNT_WIDTH-1:0] cfg_cons,
  input  logic [AW:0]            cfg_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COUNT_WIDTH-1:0] in_pkt_1,
  input  logic [COUNT_WIDTH-1:0] in_pkt_2,
  input  logic [COUNT_WIDTH-1:0] in_pkt_3,
  output logic [COUNT_WIDTH-1:0] alu_pkt_1,
  output logic [COUNT_WIDTH-1:0] alu_pkt_2,
  output logic [COUNT_WIDTH-1:0] alu_pkt_3,
  output logic [COUNT_WIDTH-1:0] alu_cons_1,
  output logic [3:0]             alu_opcode,
  output logic [1:0]             alu_sel_1,
  output logic [1:0]             alu_sel_2,
  output logic [1:0]             alu_sel_3,
  output logic [1:0]             alu_sel_4,
  output logic [1:0]             alu_sel_5,
  input  logic [COUNT_WIDTH-1:0] alu_o_write,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] out_pkt_1,
  output logic [COUNT_WIDTH-1:0] out_pkt_2,
  output logic [COUNT_WIDTH-1:0] out_pkt_3,
  output logic [COUNT_WIDTH-1:0] out_result,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t                 state_q, state_d;
  logic [15:0]            instr_mem [DEPTH];
  logic [COUNT_WIDTH-1:0] cons_mem  [DEPTH];
  logic [AW-1:0]          pc;
  logic [AW:0]            len;
  logic [COUNT_WIDTH-1:0] pkt_1, pkt_2, pkt_3, result;

  logic [15:0]            cur_instr;
  logic [AW:0]            len_in;
  logic                   accept, nop, last;
  logic [1:0]             dst;

  assign cur_instr = instr_mem[pc];
  assign nop       = &cur_instr[15:14];
  assign dst       = cur_instr[1:0];
  assign len_in    = (cfg_len > DEPTH_L) ? DEPTH_L : cfg_len;
  assign accept    = (state_q == IDLE) && in_valid && !cfg_we;
  assign last      = ({1'b0, pc} == (len - 1'b1));

  assign out_pkt_1  = pkt_1;
  assign out_pkt_2  = pkt_2;
  assign out_pkt_3  = pkt_3;
  assign out_result = result;

  // Program store only accepts writes while no packet is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        cons_mem[i]  <= '0;
      end
    end else if (cfg_we && (state_q == IDLE)) begin
      instr_mem[cfg_addr] <= cfg_instr;
      cons_mem[cfg_addr]  <= cfg_cons;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = (state_q != IDLE);
    alu_pkt_1  = '0;
    alu_pkt_2  = '0;
    alu_pkt_3  = '0;
    alu_cons_1 = '0;
    alu_opcode = '0;
    alu_sel_1  = '0;
    alu_sel_2  = '0;
    alu_sel_3  = '0;
    alu_sel_4  = '0;
    alu_sel_5  = '0;
    case (state_q)
      IDLE: begin
        in_ready = !cfg_we;
        if (accept) state_d = (len_in == '0) ? DONE : RUN;
      end
      RUN: begin
        alu_pkt_1  = pkt_1;
        alu_pkt_2  = pkt_2;
        alu_pkt_3  = pkt_3;
        alu_cons_1 = cons_mem[pc];
        alu_opcode = cur_instr[15:12];
        alu_sel_1  = cur_instr[11:10];
        alu_sel_2  = cur_instr[9:8];
        alu_sel_3  = cur_instr[7:6];
        alu_sel_4  = cur_instr[5:4];
        alu_sel_5  = cur_instr[3:2];
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Writeback lands in the packet registers so the next slot sees it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= '0;
      len    <= '0;
      pkt_1  <= '0;
      pkt_2  <= '0;
      pkt_3  <= '0;
      result <= '0;
    end else if (accept) begin
      pc     <= '0;
      len    <= len_in;
      pkt_1  <= in_pkt_1;
      pkt_2  <= in_pkt_2;
      pkt_3  <= in_pkt_3;
      result <= '0;
    end else if (state_q == RUN) begin
      pc <= pc + 1'b1;
      if (!nop) begin
        result <= alu_o_write;
        case (dst)
          2'd0:    pkt_1 <= alu_o_write;
          2'd1:    pkt_2 <= alu_o_write;
          2'd2:    pkt_3 <= alu_o_write;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/stateless_seq.md
# stateless_seq

Micro-sequencer that time-shares one `stateless` ALU atom across a short per-packet program. It holds a DEPTH-slot instruction store (opcode, operand selects, constant, destination field), accepts one packet (three 32-bit fields) per valid/ready handshake, and steps the atom through up to DEPTH instructions, one per cycle. Each result is written back into a packet field, so later instructions see earlier results. It returns the final packet and last result on a valid/ready output. It sits between the parser-side packet stream and a single `stateless` instance, whose combinational `o_write` it samples.

## Interface
- DEPTH, 8: number of program slots; power of two, at least 2.
- COUNT_WIDTH, 32: data width of packet fields, constant and result.
- AW, $clog2(DEPTH): program address width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  program-slot write strobe.
- cfg_addr  in  AW  slot index.
- cfg_instr  in  16  instruction word:
  - [15:12] opcode
  - [11:10] sel_1, [9:8] sel_2
  - [7:6] sel_3, [5:4] sel_4, [3:2] sel_5
  - [1:0] dst: 0 = pkt_1, 1 = pkt_2, 2 = pkt_3, 3 = no writeback.
- cfg_cons  in  COUNT_WIDTH  slot constant (drives cons_1).
- cfg_len  in  AW+1  program length; sampled at packet accept.
- in_valid, in_ready  in/out  1  packet-input handshake.
- in_pkt_1, in_pkt_2, in_pkt_3  in  COUNT_WIDTH  packet fields.
- alu_pkt_1, alu_pkt_2, alu_pkt_3, alu_cons_1  out  COUNT_WIDTH  ALU operands.
- alu_opcode  out  4  ALU opcode.
- alu_sel_1 … alu_sel_5  out  2 each  ALU selects.
- alu_o_write  in  COUNT_WIDTH  ALU combinational result.
- out_valid, out_ready  out/in  1  result handshake.
- out_pkt_1, out_pkt_2, out_pkt_3, out_result  out  COUNT_WIDTH  final packet and last result.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready = !cfg_we`.
  - A slot write commits on the edge where cfg_we=1. Writes in RUN or DONE are dropped.
  - On accept (in_valid & in_ready):
    - latch the three packet fields, clear the result register, set pc = 0;
    - latch len = min(cfg_len, DEPTH);
    - go to RUN if len > 0, otherwise go to DONE.
- RUN:
  - Drive the alu_* ports from slot[pc] and the current packet registers.
  - At the clock edge, sample alu_o_write into the result register and into field dst; dst = 3 means no field write.
  - Increment pc. When pc == len-1, go to DONE.
  - Opcode 12–15 is a NOP: no field write, result unchanged, pc still advances.
- DONE:
  - out_valid = 1. out_* hold the packet and result registers.
  - On out_ready, go to IDLE.
- Outside RUN, all alu_* outputs are driven to 0.
- Arithmetic is entirely inside the atom; the sequencer does no width conversion.
- Reset, including mid-RUN or mid-DONE:
  - state IDLE, pc 0, all packet and result registers 0;
  - all slots cleared to instr 0 and cons 0;
  - out_valid 0, in_ready 1, busy 0, all alu_* 0. Any in-flight packet is discarded.

## Timing
- Accept on the cycle-T edge. RUN occupies cycles T+1 … T+len. out_valid rises in cycle T+len+1; for len = 0 it rises in cycle T+1.
- out_* are stable from out_valid rising until the cycle out_ready is sampled high.
- in_ready rises the cycle after the output handshake.
- Throughput: one packet per len+2 cycles with out_ready held high.
- A slot written on an edge is visible to a packet accepted on a later edge. Write and accept never occur in the same cycle.
- alu_o_write is sampled within the RUN cycle; the atom's registered o_read is not used.

## Test plan
- Add, single slot:
  - Stimulus: slot0 = opcode 0, sel_1 = 0, sel_2 = 1, dst = 2; len = 1; packet (5, 7, 0) accepted at T.
  - Response: out_valid at T+2 with out_pkt_3 = 12, out_result = 12.
- Chaining:
  - Stimulus: slot0 = add pkt_1 + pkt_2 into pkt_3; slot1 = opcode 11, sel_3 = 2, sel_4 = 3, sel_5 = 0, cons = 99, dst = 3; len = 2; packet (3, 4, 0).
  - Response: out_pkt_3 = 7, out_result = 99, out_valid at T+3.
- Backpressure:
  - Stimulus: hold out_ready low for 5 cycles in DONE.
  - Response: out_* stable, in_ready = 0, busy = 1. IDLE follows the first out_ready = 1 cycle.
- Length edges:
  - len = 0 with packet (1, 2, 3): response (1, 2, 3), result 0, out_valid at T+1.
  - cfg_len = 12 with DEPTH = 8: runs 8 slots, out_valid at T+9.
- NOP and dropped write:
  - Stimulus: slot0 opcode 13 with dst = 0, then a cfg_we to slot0 during RUN.
  - Response: pkt_1 unchanged. A readback run shows slot0 still holds opcode 13.
- Reset mid-RUN:
  - Stimulus: assert rst_n low during pc = 1.
  - Response: immediately busy = 0, out_valid = 0, alu_* = 0, in_ready = 1 after release. A following len = 1 run executes the cleared slot0 (opcode 0, sel 0, dst 0) on (6, 0, 0) and gives pkt_1 = 12, result 12.
